fifo_burst_reader: RTL and testbench

- Read-side controller for the 8-bit synchronous FIFO. Pulls a programmed number of bytes out of the FIFO via its active-low output-enable and EMPTY flag.
- Presents the bytes downstream on a valid/ready stream.
- Absorbs the FIFO's one-cycle read latency with a 2-entry skid buffer, so downstream stalls never lose or duplicate data.
- Sits between the FIFO's DOUT/OE_N/EMPTY pins and the consuming logic.

---
 rtl/fifo_burst_reader.sv | 180 ++++++++++++++++++
 tb/tb_fifo_burst_reader.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
//   Read-side controller for an 8-bit synchronous FIFO. On START it pulls
//   BURST_LEN bytes out of the FIFO (active-low FIFO_OE_N, one-cycle read
//   latency) and presents them on a valid/ready stream. A 2-entry skid buffer
//   absorbs the read latency, so downstream stalls never drop or repeat data.
//
// Ports
//   CLK, RST_N        clock, asynchronous active-low reset
//   START, BURST_LEN  burst request (START honoured only in IDLE)
//   FIFO_EMPTY        FIFO empty flag
//   FIFO_DOUT         FIFO read data, valid the cycle after an accepted read
//   FIFO_OE_N         FIFO read enable, active-low, combinational
//   M_DATA, M_VALID   stream output (head of the skid buffer)
//   M_READY           stream ready from downstream
//   BUSY              high while the burst is running or draining
//   DONE              one-cycle pulse once the burst has fully left the block
//   RD_COUNT          FIFO reads accepted in the current or last burst
//
// Stream handshake: a beat transfers at a rising edge where M_VALID and
// M_READY are both high. M_VALID never drops and M_DATA never changes while
// M_VALID is high and M_READY is low.
module fifo_burst_reader #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 11
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [CNT_W-1:0] BURST_LEN,
  input  logic             FIFO_EMPTY,
  input  logic [WIDTH-1:0] FIFO_DOUT,
  output logic             FIFO_OE_N,
  output logic [WIDTH-1:0] M_DATA,
  output logic             M_VALID,
  input  logic             M_READY,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] RD_COUNT
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] rd_count_q, rd_count_d;   // doubles as the issued count
  logic             inflight_q, inflight_d;   // FIFO_DOUT holds a byte to capture
  logic [1:0]       occ_q, occ_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;

  logic       pop;
  logic       rd_acc;
  logic       room;
  logic [1:0] fill;
  logic [1:0] occ_mid;

  assign M_VALID  = (occ_q != 2'd0);
  assign M_DATA   = head_q;
  assign RD_COUNT = rd_count_q;
  assign pop      = M_VALID & M_READY;

  // Bytes already committed to the buffer (stored or arriving next edge).
  // A new read is safe if that total, less this cycle's pop, stays below 2;
  // this keeps 1 byte/cycle throughput while the buffer can never overflow.
  assign fill   = occ_q + {1'b0, inflight_q};
  assign room   = (fill != 2'd2) | pop;
  assign rd_acc = ~FIFO_OE_N & ~FIFO_EMPTY;

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and burst bookkeeping
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    rd_count_d = rd_count_q;
    if (rd_acc) begin
      rd_count_d = rd_count_q + CNT_W'(1);
    end
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d    = S_RUN;
          len_d      = BURST_LEN;
          rd_count_d = '0;
        end
      end
      S_RUN: begin
        if (rd_count_q == len_q) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!inflight_q && (occ_q == 2'd0)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    FIFO_OE_N = 1'b1;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    unique case (state_q)
      S_RUN: begin
        BUSY = 1'b1;
        if (!FIFO_EMPTY && (rd_count_q < len_q) && room) begin
          FIFO_OE_N = 1'b0;
        end
      end
      S_DRAIN: begin
        BUSY = 1'b1;
      end
      S_DONE: begin
        DONE = 1'b1;
      end
      default: begin
        FIFO_OE_N = 1'b1;
      end
    endcase
  end

  // Skid buffer: pop shifts the tail into the head, then the arriving byte
  // lands in the first free slot. Capture and pop in one cycle both apply.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    occ_mid    = occ_q - {1'b0, pop};
    inflight_d = rd_acc;
    if (pop) begin
      head_d = tail_q;
    end
    if (inflight_q) begin
      if (occ_mid == 2'd0) begin
        head_d = FIFO_DOUT;
      end else begin
        tail_d = FIFO_DOUT;
      end
    end
    occ_d = occ_mid + {1'b0, inflight_q};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      len_q      <= '0;
      rd_count_q <= '0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      len_q      <= len_d;
      rd_count_q <= rd_count_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Testbench for fifo_burst_reader: behavioural FIFO, table of bursts plus
// hand-written corner-case sequences, expected-byte queue as scoreboard.
module tb_fifo_burst_reader;

  localparam int WIDTH = 8;
  localparam int CNT_W = 11;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  logic             START;
  logic [CNT_W-1:0] BURST_LEN;
  logic             FIFO_EMPTY;
  logic [WIDTH-1:0] FIFO_DOUT;
  logic             FIFO_OE_N;
  logic [WIDTH-1:0] M_DATA;
  logic             M_VALID;
  logic             M_READY;
  logic             BUSY;
  logic             DONE;
  logic [CNT_W-1:0] RD_COUNT;

  fifo_burst_reader #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .BURST_LEN(BURST_LEN),
    .FIFO_EMPTY(FIFO_EMPTY), .FIFO_DOUT(FIFO_DOUT), .FIFO_OE_N(FIFO_OE_N),
    .M_DATA(M_DATA), .M_VALID(M_VALID), .M_READY(M_READY),
    .BUSY(BUSY), .DONE(DONE), .RD_COUNT(RD_COUNT)
  );

  // ---------------- state ----------------
  typedef struct {
    int preload;   // bytes written to the FIFO before START
    int len;       // BURST_LEN
    int mode;      // 0 ready=1, 1 toggle, 2 random, 3 ready=0
    int exp_rd;    // expected RD_COUNT and number of beats
    int exp_left;  // bytes expected to remain in the FIFO
  } vec_t;

  vec_t vecs[8];

  logic [WIDTH-1:0] fifo_q[$];   // FIFO model contents
  logic [WIDTH-1:0] exp_q[$];    // scoreboard: bytes expected on the stream

  int n_checks, n_errors;
  int cyc, done_cnt, oe_low_cnt;
  int n_reads, n_pops, held_base;
  int vbeats, first_beat, last_beat;
  int ready_mode;
  logic rd_next;
  logic stall_prev;
  logic [WIDTH-1:0] stall_data;
  logic [WIDTH-1:0] next_byte;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(next_byte);
      exp_q.push_back(next_byte);
      next_byte = next_byte + 8'd1;
    end
    FIFO_EMPTY = (fifo_q.size() == 0);
  endtask

  // One clock cycle. Called at a negedge; samples the DUT just after the
  // negedge, then updates the FIFO model and M_READY just after the posedge.
  task automatic step();
    int   held;
    logic pop;
    #1;
    pop     = M_VALID && M_READY;
    rd_next = !FIFO_OE_N && !FIFO_EMPTY;
    if (RST_N) begin
      if (stall_prev) begin
        check("hold_valid", M_VALID, 1);
        check("hold_data", M_DATA, stall_data);
      end
      if (!FIFO_OE_N) begin
        oe_low_cnt++;
        check("oe_while_empty", FIFO_EMPTY, 0);
        check("oe_while_not_busy", BUSY, 1);
        held = n_reads - n_pops - held_base;
        check("oe_room", ((held - int'(pop)) < 2), 1);
      end
      if (pop) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL extra_beat: got data %0h, expected no beat", M_DATA);
        end else begin
          check("beat_data", M_DATA, exp_q.pop_front());
        end
        n_pops++;
        vbeats++;
        if (vbeats == 1) first_beat = cyc;
        last_beat = cyc;
      end
      if (DONE) done_cnt++;
      stall_prev = M_VALID && !M_READY;
      stall_data = M_DATA;
    end else begin
      stall_prev = 1'b0;
    end
    @(posedge CLK);
    #1;
    cyc++;
    if (rd_next) begin
      FIFO_DOUT = fifo_q.pop_front();
      n_reads++;
    end
    FIFO_EMPTY = (fifo_q.size() == 0);
    case (ready_mode)
      0:       M_READY = 1'b1;
      1:       M_READY = !M_READY;
      2:       M_READY = 1'($urandom_range(0, 1));
      default: M_READY = 1'b0;
    endcase
    @(negedge CLK);
  endtask

  task automatic pulse_start(input int len);
    START     = 1'b1;
    BURST_LEN = CNT_W'(len);
    step();
    START     = 1'b0;
  endtask

  task automatic run_to_done(input int limit, input string tag);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < limit) begin
      step();
      n++;
    end
    check({tag, "_done_seen"}, done_cnt - d0, 1);
    step();
    step();
    check({tag, "_done_once"}, done_cnt - d0, 1);
  endtask

  task automatic run_vector(input vec_t v, input string tag);
    vbeats = 0;
    write_bytes(v.preload);
    ready_mode = v.mode;
    M_READY    = (v.mode != 3);
    pulse_start(v.len);
    run_to_done(v.len * 4 + 40, tag);
    check({tag, "_rd_count"}, RD_COUNT, v.exp_rd);
    check({tag, "_beats"}, vbeats, v.exp_rd);
    check({tag, "_fifo_left"}, fifo_q.size(), v.exp_left);
    check({tag, "_exp_left"}, exp_q.size(), v.exp_left);
    check({tag, "_busy_after"}, BUSY, 0);
    if (v.mode == 0 && v.len > 0)
      check({tag, "_back_to_back"}, last_beat - first_beat, v.len - 1);
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t v;
    int   n;
    int   d0;
    int   oe0;

    RST_N = 1'b0; START = 1'b0; BURST_LEN = '0; FIFO_EMPTY = 1'b1;
    FIFO_DOUT = '0; M_READY = 1'b0;
    n_checks = 0; n_errors = 0; cyc = 0; done_cnt = 0; oe_low_cnt = 0;
    n_reads = 0; n_pops = 0; held_base = 0; vbeats = 0; first_beat = 0;
    last_beat = 0; ready_mode = 3; rd_next = 1'b0; stall_prev = 1'b0;
    stall_data = '0; next_byte = 8'h00;

    vecs[0] = '{10,   10,   0, 10,   0};
    vecs[1] = '{4,    4,    1, 4,    0};
    vecs[2] = '{6,    3,    2, 3,    3};
    vecs[3] = '{0,    3,    2, 3,    0};
    vecs[4] = '{0,    0,    0, 0,    0};
    vecs[5] = '{1,    1,    1, 1,    0};
    vecs[6] = '{5,    5,    2, 5,    0};
    vecs[7] = '{2047, 2047, 0, 2047, 0};

    // reset state
    @(negedge CLK);
    #1;
    check("rst_oe_n", FIFO_OE_N, 1);
    check("rst_m_valid", M_VALID, 0);
    check("rst_m_data", M_DATA, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_rd_count", RD_COUNT, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    step();
    step();

    for (int i = 0; i < 8; i++) run_vector(vecs[i], $sformatf("v%0d", i));

    // first-read latency: OE_N low in k+1, M_VALID first after edge k+2
    vbeats = 0;
    write_bytes(3);
    ready_mode = 0;
    M_READY = 1'b1;
    pulse_start(3);
    check("lat_oe_k1", FIFO_OE_N, 0);
    check("lat_valid_k1", M_VALID, 0);
    check("lat_busy_k1", BUSY, 1);
    step();
    check("lat_valid_k2", M_VALID, 0);
    step();
    check("lat_valid_k3", M_VALID, 1);
    check("lat_data_k3", M_DATA, exp_q[0]);
    run_to_done(40, "lat");
    check("lat_rd_count", RD_COUNT, 3);

    // zero-length burst with bytes waiting; START during DONE ignored
    write_bytes(2);
    oe0 = oe_low_cnt;
    d0  = done_cnt;
    pulse_start(0);
    check("len0_busy_k1", BUSY, 1);
    check("len0_done_k1", DONE, 0);
    step();
    check("len0_busy_k2", BUSY, 1);
    check("len0_done_k2", DONE, 0);
    step();
    check("len0_done_k3", DONE, 1);
    check("len0_busy_k3", BUSY, 0);
    START = 1'b1;
    BURST_LEN = CNT_W'(5);
    step();
    START = 1'b0;
    check("len0_done_k4", DONE, 0);
    check("start_in_done_ignored", BUSY, 0);
    step();
    check("start_in_done_idle", BUSY, 0);
    check("len0_no_oe", oe_low_cnt - oe0, 0);
    check("len0_one_done", done_cnt - d0, 1);
    check("len0_rd_count", RD_COUNT, 0);
    v = '{0, 2, 0, 2, 0};
    run_vector(v, "len0_drain");

    // FIFO empty at START, data arrives 20 cycles later
    vbeats = 0;
    ready_mode = 0;
    pulse_start(3);
    for (int i = 0; i < 20; i++) begin
      step();
      check("empty_busy", BUSY, 1);
      check("empty_oe_n", FIFO_OE_N, 1);
    end
    write_bytes(3);
    run_to_done(40, "empty");
    check("empty_rd_count", RD_COUNT, 3);
    check("empty_beats", vbeats, 3);

    // second START while busy is ignored
    vbeats = 0;
    write_bytes(6);
    ready_mode = 3;
    M_READY = 1'b0;
    pulse_start(6);
    for (int i = 0; i < 6; i++) step();
    check("stall_rd_count", RD_COUNT, 2);
    check("stall_valid", M_VALID, 1);
    pulse_start(1);
    check("restart_busy", BUSY, 1);
    check("restart_rd_count", RD_COUNT, 2);
    ready_mode = 0;
    run_to_done(60, "restart");
    check("restart_rd_final", RD_COUNT, 6);
    check("restart_beats", vbeats, 6);
    check("restart_exp_left", exp_q.size(), 0);

    // reset after 5 of 20 beats, then a normal burst
    vbeats = 0;
    write_bytes(20);
    ready_mode = 0;
    M_READY = 1'b1;
    pulse_start(20);
    n = 0;
    while (vbeats < 5 && n < 100) begin
      step();
      n++;
    end
    check("rst_mid_beats", vbeats, 5);
    RST_N = 1'b0;
    #1;
    check("rst_mid_oe_n", FIFO_OE_N, 1);
    check("rst_mid_valid", M_VALID, 0);
    check("rst_mid_data", M_DATA, 0);
    check("rst_mid_busy", BUSY, 0);
    check("rst_mid_done", DONE, 0);
    check("rst_mid_rd_count", RD_COUNT, 0);
    fifo_q.delete();
    exp_q.delete();
    FIFO_EMPTY = 1'b1;
    held_base  = n_reads - n_pops;
    stall_prev = 1'b0;
    step();
    step();
    RST_N = 1'b1;
    d0 = done_cnt;
    step();
    step();
    step();
    check("rst_mid_no_done", done_cnt - d0, 0);
    check("rst_mid_idle", BUSY, 0);
    v = '{8, 8, 2, 8, 0};
    run_vector(v, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
